// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the architectural PC, runs one imem transaction at a time and
// hands each instruction to decode with a valid/stall handshake; trap beats redirect.
module fetch_controller #(
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  input  logic                  trap_i,
  input  logic                  halt_i,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [31:0]           imem_rdata_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  instr_valid_o,
  output logic [31:0]           instr_o,
  output logic [ADDR_WIDTH-1:0] instr_pc_o,
  output logic                  halted_o
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StHold, StHalted} state_e;

  state_e                state;
  logic                  kill;
  logic                  jump;
  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] next_pc;

  assign jump   = trap_i | redirect_i;
  assign target = trap_i ? TRAP_VECTOR : {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};

  // PC the block moves to this cycle if it leaves its state: a redirect target, the
  // sequential successor when an instruction is consumed, otherwise the current PC.
  always_comb begin
    next_pc = pc_o;
    if (jump) begin
      next_pc = target;
    end else if (state == StHold) begin
      next_pc = pc_o + ADDR_WIDTH'(4);
    end
  end

  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state         <= StIdle;
      kill          <= 1'b0;
      pc_o          <= RESET_VECTOR;
      imem_req_o    <= 1'b0;
      imem_addr_o   <= '0;
      instr_valid_o <= 1'b0;
      instr_o       <= '0;
      instr_pc_o    <= '0;
      halted_o      <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          pc_o <= next_pc;
          if (halt_i) begin
            state    <= StHalted;
            halted_o <= 1'b1;
          end else begin
            state       <= StReq;
            imem_req_o  <= 1'b1;
            imem_addr_o <= next_pc;
          end
        end
        StReq: begin
          // The request in flight still completes at its original address.
          if (jump) begin
            pc_o <= target;
            kill <= 1'b1;
          end
          if (imem_gnt_i) begin
            state      <= StWait;
            imem_req_o <= 1'b0;
          end
        end
        StWait: begin
          if (imem_rvalid_i) begin
            if (kill || jump) begin
              kill <= 1'b0;
              pc_o <= next_pc;
              if (halt_i) begin
                state    <= StHalted;
                halted_o <= 1'b1;
              end else begin
                state       <= StReq;
                imem_req_o  <= 1'b1;
                imem_addr_o <= next_pc;
              end
            end else begin
              state         <= StHold;
              instr_valid_o <= 1'b1;
              instr_o       <= imem_rdata_i;
              instr_pc_o    <= imem_addr_o;
            end
          end else if (jump) begin
            pc_o <= target;
            kill <= 1'b1;
          end
        end
        StHold: begin
          // A redirect overrides the consume, so stall_i does not matter then.
          if (jump || !stall_i) begin
            instr_valid_o <= 1'b0;
            pc_o          <= next_pc;
            if (halt_i) begin
              state    <= StHalted;
              halted_o <= 1'b1;
            end else begin
              state       <= StReq;
              imem_req_o  <= 1'b1;
              imem_addr_o <= next_pc;
            end
          end
        end
        StHalted: begin
          pc_o <= next_pc;
          if (!halt_i) begin
            state       <= StReq;
            halted_o    <= 1'b0;
            imem_req_o  <= 1'b1;
            imem_addr_o <= next_pc;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: a small imem responder, directed stimulus pushing expected
// instructions into a scoreboard, and a monitor that checks each newly presented instruction.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        trap_i;
  logic        halt_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] pc_o;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        halted_o;

  fetch_controller dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .trap_i        (trap_i),
    .halt_i        (halt_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .pc_o          (pc_o),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .halted_o      (halted_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          vectors     = 0;
  int          miscompares = 0;
  logic        prev_valid  = 1'b0;

  // Responder knobs: grant withheld gnt_hold cycles, rvalid delayed rv_wait cycles past grant+1.
  bit          mem_en   = 1'b0;
  int          gnt_hold = 0;
  int          rv_wait  = 0;
  bit          pend     = 1'b0;
  logic [31:0] rdata_val = 32'h0000_0013;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    exp_t x;
    x.instr = instr;
    x.pc    = pc;
    sb.push_back(x);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!instr_valid_o && n < 20) begin
      cyc(1);
      n++;
    end
    vectors++;
    if (!instr_valid_o) begin
      miscompares++;
      $display("FAIL %s: instr_valid_o got 0 expected 1 within 20 cycles", name);
    end
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!imem_req_o && n < 20) begin
      cyc(1);
      n++;
    end
    vectors++;
    if (!imem_req_o) begin
      miscompares++;
      $display("FAIL %s: imem_req_o got 0 expected 1 within 20 cycles", name);
    end
  endtask

  // Memory responder, driven on the falling edge.
  always @(negedge clk) begin
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    if (pend) begin
      if (rv_wait > 0) begin
        rv_wait--;
      end else begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = rdata_val;
        pend          = 1'b0;
      end
    end
    if (mem_en && imem_req_o && !pend) begin
      if (gnt_hold > 0) begin
        gnt_hold--;
      end else begin
        imem_gnt_i = 1'b1;
        pend       = 1'b1;
      end
    end
  end

  // Monitor: every fresh presentation of an instruction must match the oldest expectation.
  always @(negedge clk) begin
    if (instr_valid_o && !prev_valid) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_unexpected: got instr %h at pc %h expected none", instr_o, instr_pc_o);
      end else begin
        e = sb.pop_front();
        check("sb_instr", instr_o, e.instr);
        check("sb_pc", instr_pc_o, e.pc);
      end
    end
    prev_valid = instr_valid_o;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_i       = 1'b0;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    trap_i        = 1'b0;
    halt_i        = 1'b0;
    cyc(2);
    check("rst_pc", pc_o, 32'h0);
    check("rst_req", imem_req_o, 1'b0);
    check("rst_addr", imem_addr_o, 32'h0);
    check("rst_valid", instr_valid_o, 1'b0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_instr_pc", instr_pc_o, 32'h0);
    check("rst_halted", halted_o, 1'b0);

    // Straight-line fetch, one instruction every 3 cycles.
    rst_n_i = 1'b1;
    mem_en  = 1'b1;
    push(32'h0000_0013, 32'h0);
    push(32'h0000_0013, 32'h4);
    push(32'h0000_0013, 32'h8);
    cyc(1);
    check("first_req", imem_req_o, 1'b1);
    check("first_addr", imem_addr_o, 32'h0);
    cyc(2);
    check("seq0_valid", instr_valid_o, 1'b1);
    check("seq0_ipc", instr_pc_o, 32'h0);
    cyc(3);
    check("seq1_valid", instr_valid_o, 1'b1);
    check("seq1_ipc", instr_pc_o, 32'h4);
    check("seq1_pc", pc_o, 32'h4);
    cyc(3);
    check("seq2_valid", instr_valid_o, 1'b1);
    check("seq2_ipc", instr_pc_o, 32'h8);

    // Grant withheld for 5 cycles, then a 4-cycle stall in HOLD.
    gnt_hold  = 5;
    rdata_val = 32'hDEAD_BEEF;
    cyc(1);
    for (int i = 0; i < 5; i++) begin
      check("nognt_req", imem_req_o, 1'b1);
      check("nognt_addr", imem_addr_o, 32'hC);
      cyc(1);
    end
    stall_i = 1'b1;
    push(32'hDEAD_BEEF, 32'hC);
    wait_valid("stall_wait");
    for (int i = 0; i < 4; i++) begin
      check("stall_instr", instr_o, 32'hDEAD_BEEF);
      check("stall_pc", pc_o, 32'hC);
      check("stall_valid", instr_valid_o, 1'b1);
      cyc(1);
    end
    stall_i = 1'b0;
    cyc(1);
    check("consume_pc", pc_o, 32'h10);
    check("consume_valid", instr_valid_o, 1'b0);
    check("consume_addr", imem_addr_o, 32'h10);

    // Redirect in WAIT with the response still outstanding: response killed.
    rv_wait = 2;
    cyc(1);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h203;
    cyc(1);
    redirect_i = 1'b0;
    check("redir_pc", pc_o, 32'h200);
    check("redir_noreq", imem_req_o, 1'b0);
    rdata_val = 32'h0050_0093;
    push(32'h0050_0093, 32'h200);
    wait_req("redir_req");
    check("redir_addr", imem_addr_o, 32'h200);
    check("redir_killed", instr_valid_o, 1'b0);
    wait_valid("redir_valid");

    // Trap and redirect together in HOLD: trap wins.
    trap_i        = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h400;
    cyc(1);
    trap_i     = 1'b0;
    redirect_i = 1'b0;
    check("trap_pc", pc_o, 32'h100);
    check("trap_addr", imem_addr_o, 32'h100);
    check("trap_valid", instr_valid_o, 1'b0);
    rdata_val = 32'h3420_2573;
    push(32'h3420_2573, 32'h100);
    wait_valid("trap_fetch");

    // Halt raised during WAIT: response delivered, then HALTED.
    cyc(1);
    rdata_val = 32'h0000_0073;
    push(32'h0000_0073, 32'h104);
    cyc(1);
    halt_i = 1'b1;
    wait_valid("halt_deliver");
    cyc(1);
    check("halt_halted", halted_o, 1'b1);
    check("halt_pc", pc_o, 32'h108);
    cyc(3);
    check("halt_noreq", imem_req_o, 1'b0);
    halt_i = 1'b0;
    cyc(1);
    check("resume_halted", halted_o, 1'b0);
    check("resume_req", imem_req_o, 1'b1);
    check("resume_addr", imem_addr_o, 32'h108);
    rdata_val = 32'h0010_0113;
    push(32'h0010_0113, 32'h108);
    wait_valid("resume_fetch");

    // Redirect to the top of the address space (low bits masked), then wrap.
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFE;
    cyc(1);
    redirect_i = 1'b0;
    check("top_pc", pc_o, 32'hFFFF_FFFC);
    check("top_addr", imem_addr_o, 32'hFFFF_FFFC);
    rdata_val = 32'h0000_006F;
    push(32'h0000_006F, 32'hFFFF_FFFC);
    wait_valid("top_fetch");
    cyc(1);
    check("wrap_pc", pc_o, 32'h0);
    check("wrap_addr", imem_addr_o, 32'h0);

    // Reset pulsed mid-WAIT; the late rvalid must be ignored.
    rv_wait   = 1;
    rdata_val = 32'hBAD0_BAD0;
    cyc(1);
    rst_n_i = 1'b0;
    cyc(1);
    rst_n_i = 1'b1;
    check("mrst_pc", pc_o, 32'h0);
    check("mrst_req", imem_req_o, 1'b0);
    check("mrst_valid", instr_valid_o, 1'b0);
    cyc(1);
    check("mrst_req2", imem_req_o, 1'b1);
    check("mrst_addr", imem_addr_o, 32'h0);
    rdata_val = 32'h0000_0013;
    push(32'h0000_0013, 32'h0);
    wait_valid("mrst_fetch");
    cyc(2);
    check("sb_drained", sb.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
